// File: rtl/fifo_pkg.sv
// fifo_pkg: shared width helpers, default parameter values and the
// status-flag bundle used by fifo_param and fifo_param_ctrl.
package fifo_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_DEPTH    = 16;
  localparam int DEF_AE_LEVEL = 2;

  // Pointer width: enough bits to index every entry (min 1).
  function automatic int ptr_w(input int depth);
    if (depth > 1) begin
      return $clog2(depth);
    end else begin
      return 1;
    end
  endfunction

  // Counter width: one extra bit so the value DEPTH is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_param_ctrl.sv
// fifo_param_ctrl: read/write pointers, occupancy counter, level flags and
// sticky overflow/underflow. Everything here is registered except the
// per-cycle accept strobes wr_en/rd_en that steer the storage array.
module fifo_param_ctrl
  import fifo_pkg::*;
#(
  parameter  int DEPTH    = DEF_DEPTH,
  parameter  int AF_LEVEL = DEF_DEPTH - 2,
  parameter  int AE_LEVEL = DEF_AE_LEVEL,
  localparam int PTR_W    = ptr_w(DEPTH),
  localparam int CNT_W    = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             read,
  input  logic             write,
  output logic             wr_en,
  output logic             rd_en,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [CNT_W-1:0] count,
  output fifo_status_t     status
);

  // With a count of zero almostFull is only set if the threshold is zero.
  localparam logic AF_RST = (AF_LEVEL <= 0) ? 1'b1 : 1'b0;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  fifo_status_t     status_q, status_d;

  // Decide which requests are accepted; a read while full frees the slot the write needs.
  always_comb begin
    rd_en = 1'b0;
    wr_en = 1'b0;
    if (read && !status_q.empty) begin
      rd_en = 1'b1;
    end else begin
      rd_en = 1'b0;
    end
    if (write && (!status_q.full || rd_en)) begin
      wr_en = 1'b1;
    end else begin
      wr_en = 1'b0;
    end
  end

  // Next pointers, occupancy, level flags (from next count) and sticky errors.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    status_d = status_q;

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    status_d.empty        = (count_d == {CNT_W{1'b0}});
    status_d.full         = (count_d == CNT_W'(DEPTH));
    status_d.almost_empty = (count_d <= CNT_W'(AE_LEVEL));
    status_d.almost_full  = (count_d >= CNT_W'(AF_LEVEL));
    status_d.overflow     = status_q.overflow  | (write & ~wr_en);
    status_d.underflow    = status_q.underflow | (read  & ~rd_en);
  end

  // State registers with synchronous reset to the empty, error-free state.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q               <= {PTR_W{1'b0}};
      rd_ptr_q               <= {PTR_W{1'b0}};
      count_q                <= {CNT_W{1'b0}};
      status_q.empty         <= 1'b1;
      status_q.full          <= 1'b0;
      status_q.almost_empty  <= 1'b1;
      status_q.almost_full   <= AF_RST;
      status_q.overflow      <= 1'b0;
      status_q.underflow     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      status_q <= status_d;
    end
  end

  assign wr_ptr = wr_ptr_q;
  assign rd_ptr = rd_ptr_q;
  assign count  = count_q;
  assign status = status_q;

endmodule

// File: rtl/fifo_param.sv
// fifo_param: parametrised synchronous FIFO with register-array storage.
// Build option FIFO_FWFT_EN selects first-word-fall-through output
// (head word shown combinationally, 0 when empty); without it outputBus is
// a register loaded on each accepted read (1-cycle latency).
module fifo_param
  import fifo_pkg::*;
#(
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int DEPTH    = DEF_DEPTH,
  parameter  int AF_LEVEL = DEPTH - 2,
  parameter  int AE_LEVEL = DEF_AE_LEVEL,
  localparam int PTR_W    = ptr_w(DEPTH),
  localparam int CNT_W    = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             read,
  input  logic             write,
  input  logic [WIDTH-1:0] inputBus,
  output logic [WIDTH-1:0] outputBus,
  output logic             empty,
  output logic             full,
  output logic             almostEmpty,
  output logic             almostFull,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             underflow
);

  logic             wr_en_s;
  logic             rd_en_s;
  logic [PTR_W-1:0] wr_ptr_s;
  logic [PTR_W-1:0] rd_ptr_s;
  fifo_status_t     status_s;

  logic [WIDTH-1:0] mem_q [DEPTH];

  fifo_param_ctrl #(
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF_LEVEL),
    .AE_LEVEL (AE_LEVEL)
  ) u_ctrl (
    .clk    (clk),
    .reset  (reset),
    .read   (read),
    .write  (write),
    .wr_en  (wr_en_s),
    .rd_en  (rd_en_s),
    .wr_ptr (wr_ptr_s),
    .rd_ptr (rd_ptr_s),
    .count  (count),
    .status (status_s)
  );

  // Storage array: written on accepted pushes; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_s] <= inputBus;
    end
  end

`ifdef FIFO_FWFT_EN
  // Fall-through output: head of queue while non-empty, zero otherwise.
  always_comb begin
    outputBus = {WIDTH{1'b0}};
    if (status_s.empty) begin
      outputBus = {WIDTH{1'b0}};
    end else begin
      outputBus = mem_q[rd_ptr_s];
    end
  end
`else
  logic [WIDTH-1:0] out_q, out_d;

  // Output register next value: load the head word on an accepted read, else hold.
  always_comb begin
    out_d = out_q;
    if (rd_en_s) begin
      out_d = mem_q[rd_ptr_s];
    end else begin
      out_d = out_q;
    end
  end

  // Output register with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= {WIDTH{1'b0}};
    end else begin
      out_q <= out_d;
    end
  end

  assign outputBus = out_q;
`endif

  assign empty       = status_s.empty;
  assign full        = status_s.full;
  assign almostEmpty = status_s.almost_empty;
  assign almostFull  = status_s.almost_full;
  assign overflow    = status_s.overflow;
  assign underflow   = status_s.underflow;

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: directed + randomized bench for fifo_param (8x8, AF=6, AE=2).
// A queue-based reference model decides acceptance from the FIFO rules;
// popped words go to a scoreboard queue checked by an independent monitor.
module tb_fifo_param;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             read = 1'b0;
  logic             write = 1'b0;
  logic [WIDTH-1:0] inputBus = 8'h00;
  logic [WIDTH-1:0] outputBus;
  logic             empty;
  logic             full;
  logic             almostEmpty;
  logic             almostFull;
  logic [3:0]       count;
  logic             overflow;
  logic             underflow;

  int checks = 0;
  int errors = 0;

  logic [7:0] mq[$];     // model contents, head at index 0
  logic [7:0] exp_q[$];  // scoreboard: words the DUT must present on reads
  bit         ovf_m = 1'b0;
  bit         unf_m = 1'b0;
  bit         rd_fire = 1'b0;

  fifo_param #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF),
    .AE_LEVEL (AE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .read        (read),
    .write       (write),
    .inputBus    (inputBus),
    .outputBus   (outputBus),
    .empty       (empty),
    .full        (full),
    .almostEmpty (almostEmpty),
    .almostFull  (almostFull),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: drive at negedge, update model, check state after posedge.
  task automatic cycle(input bit r, input bit w, input logic [7:0] d, input bit rst);
    bit rd_acc;
    bit wr_acc;
    int n;
    @(negedge clk);
    reset    = rst;
    read     = r;
    write    = w;
    inputBus = d;
    if (rst) begin
      mq.delete();
      exp_q.delete();
      ovf_m   = 1'b0;
      unf_m   = 1'b0;
      rd_fire = 1'b0;
    end else begin
      rd_acc = r && (mq.size() > 0);
      wr_acc = w && ((mq.size() < DEPTH) || rd_acc);
      if (r && !rd_acc) unf_m = 1'b1;
      if (w && !wr_acc) ovf_m = 1'b1;
      rd_fire = rd_acc;
      if (rd_acc) exp_q.push_back(mq.pop_front());
      if (wr_acc) mq.push_back(d);
    end
    @(posedge clk);
    #1;
    n = mq.size();
    chk("count",       32'(count),       32'(n));
    chk("empty",       32'(empty),       32'(n == 0));
    chk("full",        32'(full),        32'(n == DEPTH));
    chk("almostEmpty", 32'(almostEmpty), 32'(n <= AE));
    chk("almostFull",  32'(almostFull),  32'(n >= AF));
    chk("overflow",    32'(overflow),    32'(ovf_m));
    chk("underflow",   32'(underflow),   32'(unf_m));
    if (rst) chk("out_after_reset", 32'(outputBus), 32'h0);
`ifdef FIFO_FWFT_EN
    if (n == 0) chk("fwft_out_empty", 32'(outputBus), 32'h0);
    else        chk("fwft_out_head",  32'(outputBus), 32'(mq[0]));
`endif
  endtask

  // Monitor: whenever the DUT presents a read word, pop and compare.
  initial begin : monitor
    logic [7:0] e;
    forever begin
`ifdef FIFO_FWFT_EN
      @(negedge clk);
      #2;
`else
      @(posedge clk);
      #1;
`endif
      if (rd_fire) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL read_data: DUT word %0h with no expected entry", outputBus);
        end else begin
          e = exp_q.pop_front();
          if (outputBus !== e) begin
            errors++;
            $display("FAIL read_data: got %0h expected %0h at %0t", outputBus, e, $time);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int rp;
    int wp;
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);

    // Fill with 0x11..0x88, then one write too many
    for (int i = 1; i <= 8; i++) cycle(1'b0, 1'b1, 8'(i * 17), 1'b0);
    cycle(1'b0, 1'b1, 8'h99, 1'b0);
    // Drain in order, then one read too many
    for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 8'h00, 1'b0);

    // Steady state at count=4 with simultaneous read/write, pointers wrap
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 8'(8'h50 + i), 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'h00, 1'b0);

    // Full with read+write, then empty with read+write
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'(8'h60 + i), 1'b0);
    cycle(1'b1, 1'b1, 8'h70, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b1, 8'h71, 1'b0);
    cycle(1'b1, 1'b0, 8'h00, 1'b0);

    // Mid-stream reset at count=5 with overflow set
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'(8'h80 + i), 1'b0);
    cycle(1'b0, 1'b1, 8'hEE, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    cycle(1'b0, 1'b1, 8'h3C, 1'b0);
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);

    // Single word into empty FIFO, idle, then read it
    cycle(1'b0, 1'b1, 8'hA5, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);

    // Randomized traffic with shifting read/write bias and rare resets
    for (int i = 0; i < 400; i++) begin
      case ((i / 50) % 4)
        0:       begin rp = 30; wp = 70; end
        1:       begin rp = 70; wp = 30; end
        2:       begin rp = 50; wp = 50; end
        default: begin rp = 90; wp = 90; end
      endcase
      if ($urandom_range(0, 63) == 0) begin
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
      end else begin
        cycle(($urandom_range(0, 99) < rp), ($urandom_range(0, 99) < wp),
              8'($urandom_range(0, 255)), 1'b0);
      end
    end

    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
